// File: rtl/serial_sub_ctrl_if.sv
// Requester handshake plus full-subtractor cell signals for serial_sub_ctrl.
// slave is the controller's view; master is the requester/cell side.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             fs_a;
  logic             fs_b;
  logic             fs_c;
  logic             fs_diff;
  logic             fs_borrow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic [CNT_W-1:0] bit_idx;

  modport slave (
    input  start, a, b, bin, fs_diff, fs_borrow,
    output fs_a, fs_b, fs_c, busy, done, diff, borrow_out, bit_idx
  );

  modport master (
    output start, a, b, bin, fs_diff, fs_borrow,
    input  fs_a, fs_b, fs_c, busy, done, diff, borrow_out, bit_idx
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b-bin through one external full-subtractor cell, LSB first; done WIDTH+1 cycles after start.
// No backpressure: start is only accepted in IDLE and is dropped (not queued) while busy.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             brw_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             run;

  assign run   = (state_q == RUN);
  assign res_d = {bus.fs_diff, res_q[WIDTH-1:1]};

  // The cell only sees operand bits while running; idle leftovers stay hidden.
  assign bus.fs_a       = run & a_sh_q[0];
  assign bus.fs_b       = run & b_sh_q[0];
  assign bus.fs_c       = run & brw_q;
  assign bus.bit_idx    = run ? cnt_q : '0;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q  <= res_d;
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          brw_q  <= bus.fs_borrow;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            diff_q   <= res_d;
            borrow_q <= bus.fs_borrow;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboarded bench for serial_sub_ctrl with a behavioural full-subtractor cell.
module tb_serial_sub_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cyc = 0;
  int   t_first;
  int   done_seen;

  logic [WIDTH:0]   sb[$];
  logic [WIDTH-1:0] last_diff;

  serial_sub_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  serial_sub_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.fs_diff   = bus.fs_a ^ bus.fs_b ^ bus.fs_c;
  assign bus.fs_borrow = (~bus.fs_a & bus.fs_b) | (~(bus.fs_a ^ bus.fs_b) & bus.fs_c);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge with the DUT idle; returns just after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic [WIDTH:0] t;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    t = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    sb.push_back(t);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_check(input bit noise);
    bit             got = 1'b0;
    logic [WIDTH:0] e;
    for (int k = 1; k <= WIDTH + 4 && !got; k++) begin
      @(negedge clk);
      if (noise) begin
        if (k == 3 || k == 5) begin
          bus.start = 1'b1;
          bus.a     = WIDTH'($urandom);
          bus.b     = WIDTH'($urandom);
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done) begin
        got      = 1'b1;
        done_cyc = cyc;
        check("latency", 32'(k), 32'(WIDTH + 1));
        check("busy_in_done", 32'(bus.busy), 32'd1);
        check("fs_c_in_done", 32'(bus.fs_c), 32'd0);
        if (sb.size() == 0) begin
          check("sb_empty_at_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("diff", 32'(bus.diff), 32'(e[WIDTH-1:0]));
          check("borrow_out", 32'(bus.borrow_out), 32'(e[WIDTH]));
          last_diff = e[WIDTH-1:0];
        end
      end else if (k <= WIDTH) begin
        check("bit_idx", 32'(bus.bit_idx), 32'(k - 1));
        check("busy_run", 32'(bus.busy), 32'd1);
        check("diff_hold", 32'(bus.diff), 32'(last_diff));
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    last_diff = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow_out), 32'd0);
    check("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
    check("rst_fs_a", 32'(bus.fs_a), 32'd0);
    check("rst_fs_b", 32'(bus.fs_b), 32'd0);
    check("rst_fs_c", 32'(bus.fs_c), 32'd0);

    issue(8'd100, 8'd37, 1'b0);  run_check(1'b0);
    issue(8'd5, 8'd9, 1'b0);     run_check(1'b0);
    issue(8'd0, 8'd0, 1'b1);     run_check(1'b0);
    issue(8'hFF, 8'hFF, 1'b0);   run_check(1'b0);

    // Restarts during RUN must be dropped.
    issue(8'h3C, 8'h11, 1'b1);   run_check(1'b1);

    // Abort in RUN cycle 4.
    issue(8'd50, 8'd20, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    last_diff = '0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_borrow", 32'(bus.borrow_out), 32'd0);
    check("abort_bit_idx", 32'(bus.bit_idx), 32'd0);
    done_seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    issue(8'd200, 8'd1, 1'b0);   run_check(1'b0);

    // Back-to-back: second start in the first IDLE cycle after done.
    issue(8'd77, 8'd120, 1'b0);  run_check(1'b0);
    t_first = done_cyc;
    issue(8'd240, 8'd15, 1'b1);  run_check(1'b0);
    check("done_spacing", 32'(done_cyc - t_first), 32'(WIDTH + 2));

    for (int i = 0; i < 5; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      run_check(1'b0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
